// File: rtl/integral_image_gen.sv
// Streaming summed-area generator: raster 8-bit pixels in,
// one 32-bit integral value per pixel out, tagged with its word address.
module integral_image_gen #(
  parameter int MAX_WIDTH = 768,
  parameter int PIX_W     = 8,
  parameter int SUM_W     = 32,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       img_width,
  input  logic [15:0]       img_height,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic [SUM_W-1:0]  sum_data,
  output logic [ADDR_W-1:0] sum_addr,
  output logic              sum_last,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam int IDX_W = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  state_t state, state_nxt;

  logic [15:0]       w_q;
  logic [15:0]       h_q;
  logic [15:0]       col;
  logic [15:0]       row;
  logic [SUM_W-1:0]  row_acc;
  logic [ADDR_W-1:0] addr;

  logic [SUM_W-1:0] lb [MAX_WIDTH];

  logic             cfg_ok;
  logic             accept;
  logic             col_end;
  logic             row_end;
  logic             out_take;
  logic [SUM_W-1:0] lb_rd;
  logic [SUM_W-1:0] row_nxt;
  logic [SUM_W-1:0] ii;

  assign cfg_ok = (img_width != 16'd0) &&
                  (img_width <= 16'(MAX_WIDTH)) &&
                  (img_height != 16'd0);

  assign accept   = pix_valid && pix_ready;
  assign out_take = sum_valid && sum_ready;
  assign col_end  = (col == w_q - 16'd1);
  assign row_end  = (row == h_q - 16'd1);

  // Row 0 has no row above; the buffer still holds the old frame.
  assign lb_rd   = (row == 16'd0) ? '0 : lb[col[IDX_W-1:0]];
  assign row_nxt = row_acc + SUM_W'(pix_data);
  assign ii      = row_nxt + lb_rd;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pix_ready = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && cfg_ok) state_nxt = RUN;
      end
      RUN: begin
        pix_ready = !sum_valid || sum_ready;
        if (accept && col_end && row_end) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (out_take) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) lb[col[IDX_W-1:0]] <= ii;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_q       <= '0;
      h_q       <= '0;
      col       <= '0;
      row       <= '0;
      row_acc   <= '0;
      addr      <= '0;
      sum_valid <= 1'b0;
      sum_data  <= '0;
      sum_addr  <= '0;
      sum_last  <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      if (state == IDLE) begin
        if (start && cfg_ok) begin
          w_q     <= img_width;
          h_q     <= img_height;
          col     <= '0;
          row     <= '0;
          row_acc <= '0;
          addr    <= '0;
        end else if (start) begin
          cfg_err <= 1'b1;
        end
      end else if (state == RUN) begin
        if (out_take) sum_valid <= 1'b0;
        if (accept) begin
          sum_valid <= 1'b1;
          sum_data  <= ii;
          sum_addr  <= addr;
          sum_last  <= col_end && row_end;
          addr      <= addr + 1'b1;
          if (col_end) begin
            col     <= '0;
            row     <= row + 16'd1;
            row_acc <= '0;
          end else begin
            col     <= col + 16'd1;
            row_acc <= row_nxt;
          end
        end
      end else if (state == FLUSH) begin
        if (out_take) begin
          sum_valid <= 1'b0;
          sum_last  <= 1'b0;
          done      <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/integral_image_gen.md
Name: integral_image_gen

Overview:
Streaming summed-area (integral image) generator that feeds each detection core. It takes the core's raw 8-bit greyscale pixel tile in raster order and emits one 32-bit integral value per pixel, each tagged with its linear word address (row * width + col). That address matches the layout the downstream detector indexes, where "next row" = +width. The downstream detector computes every rectangle mean as four corner reads, so this block defines the numeric contract for the whole detection path.

Parameters:
MAX_WIDTH, 768, maximum tile side in pixels; sizes the line buffer (3 * size/8 for size = 2048)
PIX_W, 8, pixel width in bits
SUM_W, 32, integral value width in bits
ADDR_W, 32, output word address width

Ports:
clk  input  1  clock, all logic rising-edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle frame start request; sampled only in IDLE
img_width  input  16  tile width in pixels; latched on accepted start
img_height  input  16  tile height in pixels; latched on accepted start
pix_valid  input  1  upstream pixel valid
pix_ready  output  1  block can accept a pixel this cycle
pix_data  input  PIX_W  unsigned pixel value
sum_valid  output  1  output word valid
sum_ready  input  1  downstream accepts the output word
sum_data  output  SUM_W  integral value ii(x,y)
sum_addr  output  ADDR_W  y*img_width + x
sum_last  output  1  high with the final word of the frame
busy  output  1  high outside IDLE
done  output  1  one-cycle pulse after the last word is accepted
cfg_err  output  1  one-cycle pulse when start carries invalid dimensions

Behaviour:
- Reset values: pix_ready=0, sum_valid=0, sum_data=0, sum_addr=0, sum_last=0, busy=0, done=0, cfg_err=0. FSM=IDLE; col, row, row_acc and addr counters = 0. Line buffer contents are don't-care.
- Definition: ii(x,y) = sum of p(i,j) for i<=x, j<=y. Implement as row_acc(x,y) = row_acc(x-1,y) + p(x,y), and ii(x,y) = row_acc(x,y) + lb[x]. lb[x] holds ii(x,y-1) and is treated as 0 when y=0.
- Arithmetic: unsigned, zero-extended to SUM_W, modulo 2^SUM_W. No saturation. The 768x768 all-255 maximum of 150,405,120 fits.
- FSM states: IDLE, RUN, FLUSH.
- IDLE: pix_ready=0.
  - start=1 with 1<=img_width<=MAX_WIDTH and img_height>=1: latch dimensions, clear counters, go to RUN next cycle.
  - start=1 with any other dimensions: pulse cfg_err next cycle and stay in IDLE.
  - start outside IDLE is ignored.
- RUN:
  - pix_ready = !sum_valid || sum_ready (single output register, no bubble under continuous flow).
  - Accept on pix_valid && pix_ready. Same edge: load sum_data/sum_addr, set sum_valid, write lb[col]=ii. The lb read at col uses the old contents (read-before-write), and row_acc updates.
  - col wraps at img_width-1 to 0, with row+1 and row_acc cleared. addr increments by 1 per accepted pixel.
  - Accepting pixel (img_width-1, img_height-1) sets sum_last with that word and moves to FLUSH.
- FLUSH: pix_ready=0. When sum_valid && sum_ready, clear sum_valid/sum_last, pulse done for one cycle, return to IDLE.
- Latency: output word valid the cycle after acceptance (1 cycle). Throughput is 1 pixel/cycle when sum_ready=1.
- Backpressure: while sum_valid && !sum_ready, all output fields hold stable and pix_ready=0.
- Upstream pix_valid may drop at any time; the block idles without loss.
- pix_valid in IDLE or FLUSH is not accepted.
- Reset mid-frame: immediately return to reset values. No partial done. The next frame needs a new start.

Test Plan:
- 3x3 tile, all pixels 1, sum_ready=1 -> sum_data sequence 1,2,3,2,4,6,3,6,9; sum_addr 0..8; sum_last only on word 8; done pulses once, one cycle after.
- 2x2 tile, pixels 10,20,30,40 with sum_ready toggling 1,0,0,1,... -> words 10,30,40,100 in order, each held stable while stalled; pix_ready=0 during stalls.
- 768x768 tile, all 255 -> final word 150,405,120 at addr 589,823; word at addr 767 = 195,840.
- start with img_width=0, then with img_width=769 -> cfg_err pulse each time, busy stays 0, no output.
- Reset asserted after 5 pixels of a 4x4 frame, then new start with 4x4 all 2 -> first word 2 at addr 0, last word 32 at addr 15.
- start pulsed during RUN -> ignored; frame completes with correct 16 words and one done.
